// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the detection-event counter and its digit cells.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  function automatic logic is_bcd_max(input bcd_digit_t d);
    return d == BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of a ripple BCD counter: increments on inc_in, rolls 9 -> 0 and
// asserts carry_out in the same cycle so the next decade steps with it.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc_in,
  output logic [BCD_W-1:0] q,
  output logic             carry_out
);

  bcd_digit_t q_q;
  bcd_digit_t q_d;

  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (inc_in) begin
      q_d = is_bcd_max(q_q) ? '0 : q_q + 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours; blocking here would race the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q         = q_q;
  assign carry_out = inc_in & is_bcd_max(q_q);

endmodule

// File: rtl/detect_event_counter.sv
// Counts 0->1 transitions of the sequence detector's z output as a BCD tally,
// with a one-cycle event strobe and a sticky overflow flag.
module detect_event_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    z,
  input  logic                    clear,
  output logic [BCD_W*DIGITS-1:0] count_bcd,
  output logic                    event_pulse,
  output logic                    overflow
);

  logic              z_q;
  logic              evt;
  logic              all_nine;
  logic              inc;
  logic              ovf_set;
  logic              event_pulse_q;
  logic              event_pulse_d;
  logic              overflow_q;
  logic              overflow_d;
  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] nine;

  assign evt = z & ~z_q;

  // Saturating mode drops the increment that would roll the maximum over.
  assign inc      = evt & ~(~WRAP & all_nine);
  assign carry[0] = inc;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .inc_in    (carry[i]),
      .q         (count_bcd[BCD_W*i +: BCD_W]),
      .carry_out (carry[i+1])
    );
    assign nine[i] = is_bcd_max(count_bcd[BCD_W*i +: BCD_W]);
  end

  assign all_nine = &nine;
  assign ovf_set  = WRAP ? carry[DIGITS] : (evt & all_nine);

  always_comb begin
    event_pulse_d = 1'b0;
    overflow_d    = overflow_q;
    if (clear) begin
      overflow_d = 1'b0;
    end else begin
      event_pulse_d = evt;
      if (ovf_set) begin
        overflow_d = 1'b1;
      end
    end
  end

  // z_q keeps sampling during clear so a level held through it is not recounted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z_q           <= 1'b0;
      event_pulse_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      z_q           <= z;
      event_pulse_q <= event_pulse_d;
      overflow_q    <= overflow_d;
    end
  end

  assign event_pulse = event_pulse_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_detect_event_counter.sv
// Scoreboard bench: drives a wrapping and a saturating counter side by side
// against an integer reference model of the event tally.
module tb_detect_event_counter;

  localparam int unsigned DIGITS = 4;
  localparam int          MAXV   = 9999;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        z = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] cnt_w, cnt_s;
  logic        pulse_w, pulse_s;
  logic        ovf_w, ovf_s;

  always #5 clk = ~clk;

  detect_event_counter #(.DIGITS(DIGITS), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .z(z), .clear(clear),
    .count_bcd(cnt_w), .event_pulse(pulse_w), .overflow(ovf_w)
  );

  detect_event_counter #(.DIGITS(DIGITS), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .z(z), .clear(clear),
    .count_bcd(cnt_s), .event_pulse(pulse_s), .overflow(ovf_s)
  );

  typedef struct {
    logic [15:0] cnt_w;
    logic [15:0] cnt_s;
    logic        pulse;
    logic        ovf_w;
    logic        ovf_s;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic m_zq = 1'b0;
  int   m_cw = 0;
  int   m_cs = 0;
  logic m_pulse = 1'b0;
  logic m_ow = 1'b0;
  logic m_os = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_zq = 1'b0; m_cw = 0; m_cs = 0; m_pulse = 1'b0; m_ow = 1'b0; m_os = 1'b0;
  endtask

  task automatic step(input logic zi, input logic ci);
    exp_t e;
    logic ev;
    @(negedge clk);
    z = zi;
    clear = ci;
    ev = zi & ~m_zq;
    if (ci) begin
      m_cw = 0; m_cs = 0; m_ow = 1'b0; m_os = 1'b0; m_pulse = 1'b0;
    end else begin
      m_pulse = ev;
      if (ev) begin
        if (m_cw == MAXV) begin m_cw = 0; m_ow = 1'b1; end
        else m_cw++;
        if (m_cs == MAXV) m_os = 1'b1;
        else m_cs++;
      end
    end
    m_zq = zi;
    e.cnt_w = to_bcd(m_cw);
    e.cnt_s = to_bcd(m_cs);
    e.pulse = m_pulse;
    e.ovf_w = m_ow;
    e.ovf_s = m_os;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("cnt_wrap",  32'(cnt_w),   32'(e.cnt_w));
    check("cnt_sat",   32'(cnt_s),   32'(e.cnt_s));
    check("pulse_wrap", 32'(pulse_w), 32'(e.pulse));
    check("pulse_sat",  32'(pulse_s), 32'(e.pulse));
    check("ovf_wrap",  32'(ovf_w),   32'(e.ovf_w));
    check("ovf_sat",   32'(ovf_s),   32'(e.ovf_s));
  endtask

  task automatic pulse_event();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_cnt_wrap", 32'(cnt_w), 32'h0);
    check("rst_cnt_sat",  32'(cnt_s), 32'h0);
    check("rst_pulse",    32'(pulse_w | pulse_s), 32'h0);
    check("rst_ovf",      32'(ovf_w | ovf_s), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Idle after reset
    repeat (10) step(1'b0, 1'b0);

    // Level vs edge: z 0,1,1,1,0,1,0
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    check("level_edge_cnt", 32'(cnt_w), 32'h0002);

    step(1'b0, 1'b1);

    // Ramp through every carry boundary up to the maximum
    while (m_cw < MAXV) pulse_event();
    check("at_max", 32'(cnt_w), 32'h9999);
    pulse_event();
    check("wrap_cnt", 32'(cnt_w), 32'h0000);
    check("sat_cnt",  32'(cnt_s), 32'h9999);
    pulse_event();
    pulse_event();

    // Clear concurrent with a z rise, then z held high
    step(1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("clear_hold_cnt", 32'(cnt_w), 32'h0000);

    // Async reset mid-count at 42
    repeat (42) pulse_event();
    check("pre_reset_cnt", 32'(cnt_w), 32'h0042);
    #2;
    reset = 1'b1;
    #1;
    check("async_cnt_wrap", 32'(cnt_w), 32'h0);
    check("async_cnt_sat",  32'(cnt_s), 32'h0);
    check("async_ovf",      32'(ovf_w | ovf_s), 32'h0);
    check("async_pulse",    32'(pulse_w | pulse_s), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0);
    check("post_reset_cnt", 32'(cnt_w), 32'h0001);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    if (exp_q.size() != 0) check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
